// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood window generator over a raster pixel stream.
// Two line buffers supply the rows above the incoming pixel; the window is a 3x3 shift register.
module window_3x3_gen #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pix_valid,
  input  logic [WIDTH-1:0]         pix_in,
  input  logic                     sof,
  output logic                     win_valid,
  output logic [9*WIDTH-1:0]       win,
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y,
  output logic                     eof
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic [XW-1:0]        col_q, col_d, cur_col;
  logic [YW-1:0]        row_q, row_d, cur_row;
  logic [9*WIDTH-1:0]   win_q, win_d;
  logic [XW-1:0]        win_x_q, win_x_d;
  logic [YW-1:0]        win_y_q, win_y_d;
  logic                 win_valid_q, win_valid_d;
  logic                 eof_q, eof_d;
  logic                 last_col, last_row;

  // lb1 holds row-1, lb2 holds row-2, both indexed by column.
  logic [WIDTH-1:0]     lb1_q [IMG_W];
  logic [WIDTH-1:0]     lb2_q [IMG_W];

  // A qualified sof forces the current pixel to (0,0) whatever the counters say.
  assign cur_col  = sof ? '0 : col_q;
  assign cur_row  = sof ? '0 : row_q;
  assign last_col = (cur_col == XW'(IMG_W - 1));
  assign last_row = (cur_row == YW'(IMG_H - 1));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    win_valid_d = 1'b0;
    eof_d       = 1'b0;
    if (pix_valid) begin
      col_d = last_col ? '0 : cur_col + 1'b1;
      if (last_col) row_d = last_row ? '0 : cur_row + 1'b1;
      else          row_d = cur_row;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 2; c++) begin
          win_d[WIDTH*(3*r+c) +: WIDTH] = win_q[WIDTH*(3*r+c+1) +: WIDTH];
        end
      end
      win_d[WIDTH*2 +: WIDTH] = lb2_q[cur_col];
      win_d[WIDTH*5 +: WIDTH] = lb1_q[cur_col];
      win_d[WIDTH*8 +: WIDTH] = pix_in;
      if (cur_col >= XW'(2) && cur_row >= YW'(2)) begin
        win_valid_d = 1'b1;
        win_x_d     = cur_col - 1'b1;
        win_y_d     = cur_row - 1'b1;
        eof_d       = last_col && last_row;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      win_valid_q <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      win_valid_q <= win_valid_d;
      eof_q       <= eof_d;
    end
  end

  // NOTE: line-buffer memories are deliberately not reset; stale entries are never emitted
  // because windows are suppressed until two fresh rows and columns have arrived.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1_q[cur_col] <= pix_in;
      lb2_q[cur_col] <= lb1_q[cur_col];
    end
  end

  assign win_valid = win_valid_q;
  assign win       = win_q;
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;
  assign eof       = eof_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x3 image with pixel value 16*y+x.
module tb_window_3x3_gen;

  localparam int WIDTH = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     pix_valid;
  logic [WIDTH-1:0]         pix_in;
  logic                     sof;
  logic                     win_valid;
  logic [9*WIDTH-1:0]       win;
  logic [$clog2(IMG_W)-1:0] win_x;
  logic [$clog2(IMG_H)-1:0] win_y;
  logic                     eof;

  // Hand-computed windows: tap(r,c) at bits WIDTH*(3r+c), so tap(0,0) is the low byte.
  localparam logic [71:0] W1 = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [71:0] W2 = 72'h23_22_21_13_12_11_03_02_01;

  int n_vec = 0;
  int n_err = 0;
  logic [71:0] hold_win;
  bit          hold_known;
  int          hold_x, hold_y;

  window_3x3_gen #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .pix_in    (pix_in),
    .sof       (sof),
    .win_valid (win_valid),
    .win       (win),
    .win_x     (win_x),
    .win_y     (win_y),
    .eof       (eof)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one cycle and returns at the following negedge.
  task automatic idle_step(input string tag);
    pix_valid = 1'b0;
    sof       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " idle win_valid"}, 72'(win_valid), 72'd0);
    check({tag, " idle eof"}, 72'(eof), 72'd0);
    check({tag, " idle win_x hold"}, 72'(win_x), 72'(hold_x));
    check({tag, " idle win_y hold"}, 72'(win_y), 72'(hold_y));
    if (hold_known) check({tag, " idle win hold"}, win, hold_win);
  endtask

  task automatic pixel_step(input string tag, input int idx, input bit s);
    int x, y;
    x = idx % IMG_W;
    y = idx / IMG_W;
    pix_valid = 1'b1;
    sof       = s;
    pix_in    = WIDTH'(16 * y + x);
    @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = 1'b0;
    if (idx == 10 || idx == 11) begin
      check($sformatf("%s px%0d win_valid", tag, idx), 72'(win_valid), 72'd1);
      check($sformatf("%s px%0d eof", tag, idx), 72'(eof), (idx == 11) ? 72'd1 : 72'd0);
      check($sformatf("%s px%0d win_x", tag, idx), 72'(win_x), (idx == 11) ? 72'd2 : 72'd1);
      check($sformatf("%s px%0d win_y", tag, idx), 72'(win_y), 72'd1);
      check($sformatf("%s px%0d win", tag, idx), win, (idx == 11) ? W2 : W1);
      hold_win   = (idx == 11) ? W2 : W1;
      hold_known = 1'b1;
      hold_x     = (idx == 11) ? 2 : 1;
      hold_y     = 1;
    end else begin
      check($sformatf("%s px%0d win_valid", tag, idx), 72'(win_valid), 72'd0);
      check($sformatf("%s px%0d eof", tag, idx), 72'(eof), 72'd0);
      hold_known = 1'b0;
    end
  endtask

  // Sends pixels first..first+n-1 of a frame; optional sof on the first, optional random gaps.
  task automatic run_pixels(input string tag, input int first, input int n,
                            input bit sof_first, input bit gaps);
    for (int i = first; i < first + n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) idle_step(tag);
      end
      pixel_step(tag, i, sof_first && (i == first));
    end
  endtask

  initial begin
    void'($urandom(32'h1234));
    rst_n      = 1'b0;
    pix_valid  = 1'b0;
    pix_in     = '0;
    sof        = 1'b0;
    hold_win   = '0;
    hold_known = 1'b1;
    hold_x     = 0;
    hold_y     = 0;
    repeat (2) @(negedge clk);
    check("reset win_valid", 72'(win_valid), 72'd0);
    check("reset eof", 72'(eof), 72'd0);
    check("reset win", win, 72'd0);
    check("reset win_x", 72'(win_x), 72'd0);
    check("reset win_y", 72'(win_y), 72'd0);
    rst_n = 1'b1;

    // 1: full frame, continuous valid, sof on first pixel
    run_pixels("s1", 0, 12, 1'b1, 1'b0);
    idle_step("s1");

    // 2: same frame with random gaps in pix_valid
    run_pixels("s2", 0, 12, 1'b1, 1'b1);
    idle_step("s2");

    // 3: two frames back to back, second without sof
    run_pixels("s3a", 0, 12, 1'b1, 1'b0);
    run_pixels("s3b", 0, 12, 1'b0, 1'b0);

    // 4: five pixels of a frame, then sof restarts on the sixth pixel
    run_pixels("s4pre", 0, 5, 1'b0, 1'b0);
    run_pixels("s4", 0, 12, 1'b1, 1'b0);

    // 5: asynchronous reset mid-frame while a window is on the outputs
    run_pixels("s5pre", 0, 11, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("s5 async win_valid", 72'(win_valid), 72'd0);
    check("s5 async eof", 72'(eof), 72'd0);
    check("s5 async win", win, 72'd0);
    check("s5 async win_x", 72'(win_x), 72'd0);
    check("s5 async win_y", 72'(win_y), 72'd0);
    hold_win   = '0;
    hold_known = 1'b1;
    hold_x     = 0;
    hold_y     = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_step("s5");
    run_pixels("s5", 0, 12, 1'b0, 1'b0);
    idle_step("s5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
